// File: rtl/svo_stream_check_pkg.sv
// Shared types and constants for the SVO stream checker.
package svo_stream_check_pkg;

    localparam int unsigned SVO_XYBITS = 14;
    localparam int unsigned SIG_W      = 32;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned LFSR_W     = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Rotate the running signature left by one bit.
    function automatic logic [SIG_W-1:0] sig_rotl(input logic [SIG_W-1:0] s);
        return {s[SIG_W-2:0], s[SIG_W-1]};
    endfunction

endpackage

// File: rtl/svo_lfsr16.sv
// 16-bit Galois LFSR with configurable seed and feedback mask.
module svo_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Galois step: shift right, apply the mask when the dropped bit is set.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable_i) begin
            if (lfsr_q[0]) begin
                lfsr_d = (lfsr_q >> 1) ^ MASK;
            end else begin
                lfsr_d = lfsr_q >> 1;
            end
        end
    end

    // State register, reloads the seed on reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/svo_stream_check.sv
// SVO AXI-stream sink: frame framing check, per-frame signature, good-frame count.
module svo_stream_check
    import svo_stream_check_pkg::*;
#(
    parameter int unsigned SVO_HOR_PIXELS     = 640,
    parameter int unsigned SVO_VER_PIXELS     = 480,
    parameter int unsigned SVO_BITS_PER_PIXEL = 24,
    parameter int unsigned STALL_EN           = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_axis_tvalid,
    output logic                          in_axis_tready,
    input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
    input  logic                          in_axis_tuser,
    output logic                          frame_done,
    output logic [31:0]                   frame_sig,
    output logic [15:0]                   frame_count,
    output logic                          err_sof_early,
    output logic                          err_sof_missing,
    output logic                          locked
);

    localparam int unsigned N_SLICE = (SVO_BITS_PER_PIXEL + 31) / 32;
    localparam int unsigned FOLD_W  = N_SLICE * 32;

    localparam logic [SVO_XYBITS-1:0] H_LAST = SVO_XYBITS'(SVO_HOR_PIXELS - 1);
    localparam logic [SVO_XYBITS-1:0] V_LAST = SVO_XYBITS'(SVO_VER_PIXELS - 1);
    localparam logic [SVO_XYBITS-1:0] XY_ONE = SVO_XYBITS'(1);

    // XOR all 32-bit slices of the zero-extended pixel.
    function automatic logic [SIG_W-1:0] fold(input logic [SVO_BITS_PER_PIXEL-1:0] p);
        logic [FOLD_W-1:0] ext;
        logic [SIG_W-1:0]  acc;
        ext = FOLD_W'(p);
        acc = '0;
        for (int unsigned i = 0; i < N_SLICE; i++) begin
            acc = acc ^ ext[i*32 +: 32];
        end
        return acc;
    endfunction

    state_e                  state_q, state_d;
    logic [SVO_XYBITS-1:0]   hcnt_q, hcnt_d;
    logic [SVO_XYBITS-1:0]   vcnt_q, vcnt_d;
    logic [SIG_W-1:0]        sig_q, sig_d;
    logic                    tready_q, tready_d;
    logic                    frame_done_q, frame_done_d;
    logic [SIG_W-1:0]        frame_sig_q, frame_sig_d;
    logic [CNT_W-1:0]        frame_count_q, frame_count_d;
    logic                    err_early_q, err_early_d;
    logic                    err_missing_q, err_missing_d;
    logic                    locked_q, locked_d;

    logic [LFSR_W-1:0]       lfsr_state;
    logic                    lfsr_unused_c;

    logic                    xfer_c;
    logic                    at_origin_c;
    logic [SIG_W-1:0]        fold_c;
    logic                    take_c;
    logic [SIG_W-1:0]        acc_sig_c;
    logic [SVO_XYBITS-1:0]   px_h_c;
    logic [SVO_XYBITS-1:0]   px_v_c;

    svo_lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk      (clk),
        .resetn   (resetn),
        .enable_i (STALL_EN != 0),
        .state_o  (lfsr_state)
    );

    assign lfsr_unused_c = ^lfsr_state[LFSR_W-1:2];

    assign xfer_c      = in_axis_tvalid & tready_q;
    assign at_origin_c = (hcnt_q == '0) && (vcnt_q == '0);
    assign fold_c      = fold(in_axis_tdata);

    // Next-state: framing decisions, position/signature advance, registered outputs.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        sig_d         = sig_q;
        tready_d      = (STALL_EN != 0) ? (lfsr_state[1:0] != 2'b00) : 1'b1;
        frame_done_d  = 1'b0;
        frame_sig_d   = frame_sig_q;
        frame_count_d = frame_count_q;
        err_early_d   = 1'b0;
        err_missing_d = 1'b0;
        locked_d      = locked_q;
        take_c        = 1'b0;
        acc_sig_c     = fold_c;
        px_h_c        = hcnt_q;
        px_v_c        = vcnt_q;

        if (xfer_c) begin
            if (state_q == ST_HUNT) begin
                if (in_axis_tuser) begin
                    state_d = ST_RUN;
                    take_c  = 1'b1;
                    px_h_c  = '0;
                    px_v_c  = '0;
                end
            end else if (at_origin_c) begin
                if (!in_axis_tuser) begin
                    err_missing_d = 1'b1;
                    locked_d      = 1'b0;
                    state_d       = ST_HUNT;
                end else begin
                    take_c = 1'b1;
                end
            end else if (in_axis_tuser) begin
                // Early SOF restarts the frame with this pixel as (0,0).
                err_early_d = 1'b1;
                locked_d    = 1'b0;
                take_c      = 1'b1;
                px_h_c      = '0;
                px_v_c      = '0;
            end else begin
                take_c    = 1'b1;
                acc_sig_c = sig_rotl(sig_q) ^ fold_c;
            end
        end

        if (take_c) begin
            if (px_h_c == H_LAST) begin
                hcnt_d = '0;
                if (px_v_c == V_LAST) begin
                    vcnt_d        = '0;
                    sig_d         = '0;
                    frame_done_d  = 1'b1;
                    frame_sig_d   = acc_sig_c;
                    frame_count_d = frame_count_q + CNT_W'(1);
                    locked_d      = 1'b1;
                end else begin
                    vcnt_d = px_v_c + XY_ONE;
                    sig_d  = acc_sig_c;
                end
            end else begin
                hcnt_d = px_h_c + XY_ONE;
                vcnt_d = px_v_c;
                sig_d  = acc_sig_c;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_HUNT;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            sig_q         <= '0;
            tready_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_sig_q   <= '0;
            frame_count_q <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            sig_q         <= sig_d;
            tready_q      <= tready_d;
            frame_done_q  <= frame_done_d;
            frame_sig_q   <= frame_sig_d;
            frame_count_q <= frame_count_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            locked_q      <= locked_d;
        end
    end

    assign in_axis_tready  = tready_q;
    assign frame_done      = frame_done_q;
    assign frame_sig       = frame_sig_q;
    assign frame_count     = frame_count_q;
    assign err_sof_early   = err_early_q;
    assign err_sof_missing = err_missing_q;
    assign locked          = locked_q;

endmodule

// File: doc/svo_stream_check.md
Name: svo_stream_check

Overview:
- Video stream sink and checker: consumes the SVO AXI-stream pixel format (tuser[0] = start of frame) at the far end of a generator or pipeline.
- Tracks pixel/line position, checks start-of-frame framing, computes a 32-bit per-frame signature and counts good frames.
- Optional pseudo-random back-pressure on tready exercises upstream handshakes.
- Used in simulation benches and as an on-chip self-test sink behind svo_tcard-style sources.

Parameters:
- SVO_HOR_PIXELS, default 640, active pixels per line (from `SVO_DEFAULT_PARAMS).
- SVO_VER_PIXELS, default 480, active lines per frame (from `SVO_DEFAULT_PARAMS).
- SVO_BITS_PER_PIXEL, default 24, tdata width (from `SVO_DEFAULT_PARAMS).
- STALL_EN, default 0, 1 = pseudo-random tready throttling, 0 = tready held high.

Ports:
- clk  in  1  clock, single domain.
- resetn  in  1  synchronous active-low reset.
- in_axis_tvalid  in  1  pixel valid.
- in_axis_tready  out  1  pixel accept.
- in_axis_tdata  in  SVO_BITS_PER_PIXEL  pixel data.
- in_axis_tuser  in  1  bit0 = start of frame.
- frame_done  out  1  one-cycle pulse, one complete frame checked.
- frame_sig  out  32  signature of the last complete frame.
- frame_count  out  16  complete good frames since reset, wraps 0xFFFF->0.
- err_sof_early  out  1  one-cycle pulse, SOF inside a frame.
- err_sof_missing  out  1  one-cycle pulse, no SOF at a frame boundary.
- locked  out  1  high once a full frame has been checked with no error since.

Behaviour:
- Reset (resetn=0 at posedge):
  - all outputs 0, state HUNT, hcnt=vcnt=0, sig accumulator=0.
  - LFSR seeded 16'hACE1.
  - tready=0 during the reset cycle.
- Transfer handling:
  - transfer = tvalid & tready; only transfers change state, counters or sig.
  - tdata/tuser are ignored when tvalid=0.
- tready:
  - STALL_EN=0: tready=1 from the first cycle after reset.
  - STALL_EN=1: 16-bit Galois LFSR (mask 16'hB400) advances every cycle; tready = (lfsr[1:0] != 0) as a registered value. tready never depends combinationally on tvalid.
- Signature step on each accepted pixel p:
  - sig_next = {sig[30:0], sig[31]} ^ fold(p).
  - fold(p) zero-extends p to a multiple of 32 bits and XORs all 32-bit slices.
  - At the first pixel of a frame, the rotate operand is 0, so sig = fold(p0).
- States:
  - HUNT:
    - transfer with tuser=0 is discarded silently.
    - transfer with tuser=1 -> RUN, hcnt=1, vcnt=0, sig=fold(p).
  - RUN, for each transfer:
    - position (0,0) and tuser=0: pulse err_sof_missing, clear locked, -> HUNT, pixel discarded.
    - position not (0,0) and tuser=1: pulse err_sof_early, clear locked, restart frame with this pixel as pixel (0,0) (hcnt=1, vcnt=0, sig=fold(p)); stay RUN. The partial frame is not counted.
    - otherwise: accumulate sig. hcnt increments; at SVO_HOR_PIXELS-1 it wraps to 0 and vcnt increments.
    - last pixel (hcnt=SVO_HOR_PIXELS-1, vcnt=SVO_VER_PIXELS-1):
      - on the next cycle frame_sig=final sig, frame_count+1, frame_done=1, locked=1;
      - position wraps to (0,0); stay RUN.
- Latency: frame_done, err pulses and frame_sig update one cycle after the triggering transfer. frame_sig holds until the next frame_done.
- A 1x1 frame size (every pixel is both first and last) must work: each SOF pixel completes a frame.
- Reset mid-frame discards all progress; the first frame after reset requires a fresh SOF.
- Counter widths: hcnt/vcnt are `SVO_XYBITS wide.

Decomposition:
- Frame geometry and widths come from svo_defines.vh macros (`SVO_DEFAULT_PARAMS, `SVO_DECLS, `SVO_XYBITS); nothing new is added there.
- State encodings (HUNT, RUN), LFSR seed and mask are localparams in this module.
- One sub-module is natural: svo_lfsr16 (clk, resetn, enable, 16-bit state out, seed/mask parameters), reusable by other SVO test blocks.

Test Plan:
- 4x2 frame, STALL_EN=0, 8 zero pixels, tuser on the first -> frame_done one cycle after the 8th transfer, frame_sig=0, frame_count=1, locked=1.
- 4x2, pixel0=24'h000001, others 0 -> frame_sig=32'h00000080; repeat 3 frames -> frame_count=3, no error pulses.
- 4x2, SOF reasserted on pixel 5 -> err_sof_early pulse, locked=0, next 8 clean pixels from that SOF -> frame_done, frame_count increments by 1 only.
- 4x2, after a good frame send pixel 0 with tuser=0 -> err_sof_missing, state HUNT; 3 more tuser=0 pixels ignored; SOF frame then completes normally.
- STALL_EN=1, source holds tvalid=1 for 640x480 tcard-like data -> tready toggles, frame_sig identical to the STALL_EN=0 run, no errors.
- resetn pulled low mid-frame (after 3 pixels) -> all outputs 0 next cycle; following full frame -> frame_count=1.
